// File: rtl/fphub_addsub_pipe_if.sv
// Stream bundle for the HUB adder: operand/op/tag in, result/tag/flags out.
// The master modport is the producer/consumer side; the slave modport is the arithmetic block.
interface fphub_addsub_pipe_if #(
    parameter int M     = 23,
    parameter int E     = 8,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [E+M:0]     in_x;
    logic [E+M:0]     in_y;
    logic             in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [E+M:0]     out_z;
    logic [TAG_W-1:0] out_tag;
    logic [3:0]       out_flags;

    modport master (
        output in_valid, in_x, in_y, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_z, out_tag, out_flags
    );

    modport slave (
        input  in_valid, in_x, in_y, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_z, out_tag, out_flags
    );
endinterface

// File: rtl/fphub_addsub_pipe.sv
// Three-stage HUB-format floating-point adder/subtractor with a valid/ready stream.
// One global advance enable moves every stage together, so a held result stalls the whole pipe.
module fphub_addsub_pipe #(
    parameter int M     = 23,
    parameter int E     = 8,
    parameter int TAG_W = 4
) (
    input logic                clk,
    input logic                rst,
    fphub_addsub_pipe_if.slave bus
);
    localparam int W  = E + M + 1;
    localparam int SW = M + 2;
    localparam int XW = E + 2;
    localparam int LW = $clog2(SW + 1);

    function automatic logic [LW-1:0] lzc(input logic [SW-1:0] v);
        logic [LW-1:0] n;
        n = LW'(SW);
        for (int i = 0; i < SW; i++)
            if (v[i]) n = LW'(SW - 1 - i);
        return n;
    endfunction

    // Normalise, truncate (HUB rounding drops the ILSB), saturate to inf or flush to zero.
    // Returns {z, flags}.
    function automatic logic [W+3:0] round_sat(input logic s, input logic [E-1:0] e,
                                               input logic [SW:0] sum, input logic [LW-1:0] lz);
        logic signed [XW-1:0] xe;
        logic [M-1:0]         mant;
        logic [W+3:0]         r;
        if (sum[SW]) begin
            xe   = $signed({2'b00, e}) + XW'(1);
            mant = M'(sum >> 2);
        end else begin
            xe   = $signed({2'b00, e}) - $signed(XW'(lz));
            mant = M'((sum[SW-1:0] << lz) >> 1);
        end
        if (sum == '0)
            r = {1'b0, {(W-1){1'b0}}, 4'b0001};
        else if (xe >= $signed({2'b00, {E{1'b1}}}))
            r = {s, {E{1'b1}}, {M{1'b0}}, 4'b0100};
        else if (xe <= 0)
            r = {s, {(W-1){1'b0}}, 4'b0011};
        else
            r = {s, xe[E-1:0], mant, 4'b0000};
        return r;
    endfunction

    logic adv;
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    logic         sx, sy;
    logic [E-1:0] ex, ey;
    logic [M-1:0] mx, my;
    assign {sx, ex, mx} = bus.in_x;
    assign sy = bus.in_y[W-1] ^ bus.in_op;
    assign ey = bus.in_y[W-2:M];
    assign my = bus.in_y[M-1:0];

    logic zx, zy, ix, iy, nx, ny;
    assign zx = (ex == '0);
    assign zy = (ey == '0);
    assign ix = (&ex) && (mx == '0);
    assign iy = (&ey) && (my == '0);
    assign nx = (&ex) && (mx != '0);
    assign ny = (&ey) && (my != '0);

    logic         spec;
    logic [W-1:0] spec_z;
    logic [3:0]   spec_f;
    always_comb begin
        spec   = 1'b1;
        spec_z = '0;
        spec_f = 4'b0000;
        if (nx || ny || (ix && iy && (sx != sy))) begin
            spec_z = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
            spec_f = 4'b1000;
        end else if (ix)
            spec_z = {sx, ex, mx};
        else if (iy)
            spec_z = {sy, ey, my};
        else if (zx && zy) begin
            spec_z = {sx & sy, {(W-1){1'b0}}};
            spec_f = 4'b0001;
        end else if (zx)
            spec_z = {sy, ey, my};
        else if (zy)
            spec_z = {sx, ex, mx};
        else
            spec = 1'b0;
    end

    logic          x_major;
    logic [SW-1:0] sig_x, sig_y, maj, mnr;
    logic [E-1:0]  de;
    logic [31:0]   shamt;
    assign x_major = (ex > ey) || ((ex == ey) && (mx >= my));
    assign sig_x   = zx ? '0 : {1'b1, mx, 1'b1};
    assign sig_y   = zy ? '0 : {1'b1, my, 1'b1};
    assign maj     = x_major ? sig_x : sig_y;
    assign mnr     = x_major ? sig_y : sig_x;
    assign de      = x_major ? ex - ey : ey - ex;
    assign shamt   = (32'(de) > 32'(M + 3)) ? 32'(M + 3) : 32'(de);

    // Stage 1 boundary: classified, swapped and aligned operands
    logic             vld_p0, spec_p0, smaj_p0, smin_p0;
    logic [W-1:0]     spz_p0;
    logic [3:0]       spf_p0;
    logic [TAG_W-1:0] tag_p0;
    logic [E-1:0]     exp_p0;
    logic [SW-1:0]    maj_p0, mnr_p0;

    always_ff @(posedge clk) begin
        if (adv) begin
            spec_p0 <= spec;
            spz_p0  <= spec_z;
            spf_p0  <= spec_f;
            tag_p0  <= bus.in_tag;
            smaj_p0 <= x_major ? sx : sy;
            smin_p0 <= x_major ? sy : sx;
            exp_p0  <= x_major ? ex : ey;
            maj_p0  <= maj;
            mnr_p0  <= mnr >> shamt;
        end
    end

    logic [SW:0] sum;
    assign sum = (smaj_p0 ^ smin_p0) ? {1'b0, maj_p0} - {1'b0, mnr_p0}
                                     : {1'b0, maj_p0} + {1'b0, mnr_p0};

    // Stage 2 boundary: raw sum/difference and its leading-zero count
    logic             vld_p1, spec_p1, sgn_p1;
    logic [W-1:0]     spz_p1;
    logic [3:0]       spf_p1;
    logic [TAG_W-1:0] tag_p1;
    logic [E-1:0]     exp_p1;
    logic [SW:0]      sum_p1;
    logic [LW-1:0]    lz_p1;

    always_ff @(posedge clk) begin
        if (adv) begin
            spec_p1 <= spec_p0;
            spz_p1  <= spz_p0;
            spf_p1  <= spf_p0;
            tag_p1  <= tag_p0;
            sgn_p1  <= smaj_p0;
            exp_p1  <= exp_p0;
            sum_p1  <= sum;
            lz_p1   <= lzc(sum[SW-1:0]);
        end
    end

    logic [W+3:0] res;
    assign res = round_sat(sgn_p1, exp_p1, sum_p1, lz_p1);

    // Stage 3 boundary: packed result registers drive the output port
    logic vld_p2;
    assign bus.out_valid = vld_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (adv) begin
            vld_p0 <= bus.in_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_z     <= '0;
            bus.out_tag   <= '0;
            bus.out_flags <= '0;
        end else if (adv && vld_p1) begin
            bus.out_z     <= spec_p1 ? spz_p1 : res[W+3:4];
            bus.out_flags <= spec_p1 ? spf_p1 : res[3:0];
            bus.out_tag   <= tag_p1;
        end
    end
endmodule

// File: tb/tb_fphub_addsub_pipe.sv
// Self-checking bench for fphub_addsub_pipe (E=8, M=23): directed corner cases,
// stall/ordering, mid-flight reset, and random normal pairs against a behavioural model.
module tb_fphub_addsub_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fphub_addsub_pipe_if #(.M(23), .E(8), .TAG_W(4)) bus ();
    fphub_addsub_pipe #(.M(23), .E(8), .TAG_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_acc = 0;
    int          n_out = 0;
    bit          last_acc = 1'b0;
    logic [39:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, required %0h", name, obs, req);
        end
    endtask

    // Value-level model: exact integer significands, truncating alignment, generic normalisation.
    function automatic logic [35:0] ref_model(input logic [31:0] x, input logic [31:0] y, input logic op);
        logic        sa, sb, st;
        int          ea, eb, et, e, p, d;
        logic [22:0] ma, mb, mt;
        logic [63:0] fa, fb, r, f;
        sa = x[31]; ea = int'(x[30:23]); ma = x[22:0];
        sb = y[31] ^ op; eb = int'(y[30:23]); mb = y[22:0];
        if ((ea == 255 && ma != 0) || (eb == 255 && mb != 0) || (ea == 255 && eb == 255 && sa != sb))
            return {32'h7FC0_0000, 4'b1000};
        if (ea == 255) return {sa, x[30:0], 4'b0000};
        if (eb == 255) return {sb, y[30:0], 4'b0000};
        if (ea == 0 && eb == 0) return {sa & sb, 31'd0, 4'b0001};
        if (ea == 0) return {sb, y[30:0], 4'b0000};
        if (eb == 0) return {x, 4'b0000};
        if (eb > ea || (eb == ea && mb > ma)) begin
            st = sa; sa = sb; sb = st;
            et = ea; ea = eb; eb = et;
            mt = ma; ma = mb; mb = mt;
        end
        d  = ea - eb;
        fa = ({40'd0, 1'b1, ma} << 1) | 64'd1;
        fb = (({40'd0, 1'b1, mb} << 1) | 64'd1) >> ((d > 26) ? 26 : d);
        r  = (sa == sb) ? fa + fb : fa - fb;
        if (r == 64'd0) return {32'h0, 4'b0001};
        p = 0;
        for (int i = 0; i < 64; i++)
            if (r[i]) p = i;
        e = ea + p - 24;
        f = (p >= 24) ? (r >> (p - 24)) : (r << (24 - p));
        if (e >= 255) return {sa, 8'hFF, 23'd0, 4'b0100};
        if (e <= 0) return {sa, 31'd0, 4'b0011};
        return {sa, e[7:0], f[23:1], 4'b0000};
    endfunction

    task automatic rnd_ops();
        int ea, eb;
        ea = int'($urandom_range(1, 254));
        if ($urandom_range(0, 1) == 1) begin
            eb = ea + int'($urandom_range(0, 60)) - 30;
            if (eb < 1) eb = 1;
            if (eb > 254) eb = 254;
        end else
            eb = int'($urandom_range(1, 254));
        bus.in_x = {1'($urandom), 8'(ea), 23'($urandom)};
        if ($urandom_range(0, 7) == 0)
            bus.in_y = {1'($urandom), 8'(ea), bus.in_x[22:0]};
        else
            bus.in_y = {1'($urandom), 8'(eb), 23'($urandom)};
        bus.in_op  = 1'($urandom);
        bus.in_tag = 4'($urandom);
    endtask

    // One clock: inputs are already driven at this falling edge.
    task automatic step();
        logic [39:0] e;
        #1;
        last_acc = 1'b0;
        if (bus.out_valid && bus.out_ready) begin
            n_out++;
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_bad++;
                $error("FAIL unexpected_result: observed tag %0h, required no result", bus.out_tag);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("result", {24'd0, bus.out_z, bus.out_flags, bus.out_tag}, {24'd0, e});
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back({ref_model(bus.in_x, bus.in_y, bus.in_op), bus.in_tag});
            n_acc++;
            last_acc = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] y,
                          input logic op, input logic [3:0] tag,
                          input logic [31:0] z_req, input logic [3:0] f_req);
        int lat;
        bus.in_x = x; bus.in_y = y; bus.in_op = op; bus.in_tag = tag;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #1;
        check({name, "_in_ready"}, bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, lat, 3);
        check({name, "_z"}, bus.out_z, z_req);
        check({name, "_flags"}, bus.out_flags, f_req);
        check({name, "_tag"}, bus.out_tag, tag);
        @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] sx[6], sy[6];
        logic        sop[6];
        logic [31:0] held_z;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.in_op = 1'b0;
        bus.in_tag = '0; bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_out_z", bus.out_z, 0);
        check("reset_out_tag", bus.out_tag, 0);
        check("reset_out_flags", bus.out_flags, 0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", bus.in_ready, 1);

        run_op("one_plus_one", 32'h3F80_0000, 32'h3F80_0000, 1'b0, 4'd3, 32'h4000_0000, 4'b0000);
        run_op("three_minus_three", 32'h4040_0000, 32'h4040_0000, 1'b1, 4'd5, 32'h0000_0000, 4'b0001);
        run_op("inf_minus_inf", 32'h7F80_0000, 32'hFF80_0000, 1'b0, 4'd6, 32'h7FC0_0000, 4'b1000);
        run_op("overflow", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 4'd7, 32'h7F80_0000, 4'b0100);
        run_op("underflow", 32'h0080_0000, 32'h00C0_0000, 1'b1, 4'd8, 32'h8000_0000, 4'b0011);
        run_op("nan_in", 32'h7FC0_0001, 32'h3F80_0000, 1'b0, 4'd9, 32'h7FC0_0000, 4'b1000);
        run_op("inf_plus_num", 32'hFF80_0000, 32'h3F80_0000, 1'b0, 4'd10, 32'hFF80_0000, 4'b0000);
        run_op("x_zero", 32'h0000_0000, 32'h3F80_0000, 1'b1, 4'd11, 32'hBF80_0000, 4'b0000);
        run_op("y_zero", 32'h3F80_0000, 32'h0000_0000, 1'b0, 4'd12, 32'h3F80_0000, 4'b0000);
        run_op("zeros_neg", 32'h8000_0000, 32'h0000_0000, 1'b1, 4'd13, 32'h8000_0000, 4'b0001);
        run_op("zeros_mixed", 32'h0000_0000, 32'h8000_0000, 1'b0, 4'd14, 32'h0000_0000, 4'b0001);
        run_op("far_shift", 32'h3F80_0000, 32'h3080_0000, 1'b1, 4'd15, 32'h3F80_0000, 4'b0000);
        run_op("one_plus_two", 32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd1, 32'h4040_0000, 4'b0000);

        // Stall: six back-to-back ops, consumer blocked for five cycles.
        for (int i = 0; i < 6; i++) begin
            rnd_ops();
            sx[i] = bus.in_x; sy[i] = bus.in_y; sop[i] = bus.in_op;
        end
        exp_q.delete(); n_acc = 0; n_out = 0; held_z = '0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (n_acc < 6) begin
                bus.in_x = sx[n_acc]; bus.in_y = sy[n_acc]; bus.in_op = sop[n_acc];
                bus.in_tag = 4'(n_acc); bus.in_valid = 1'b1;
            end
            step();
            if (c == 3) held_z = bus.out_z;
        end
        check("stall_accepted", n_acc, 3);
        check("stall_in_ready", bus.in_ready, 0);
        check("stall_out_valid", bus.out_valid, 1);
        check("stall_out_z_stable", bus.out_z, held_z);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && n_out < 6; c++) begin
            if (n_acc < 6) begin
                bus.in_x = sx[n_acc]; bus.in_y = sy[n_acc]; bus.in_op = sop[n_acc];
                bus.in_tag = 4'(n_acc); bus.in_valid = 1'b1;
            end else
                bus.in_valid = 1'b0;
            step();
        end
        check("stall_results", n_out, 6);
        bus.in_valid = 1'b0;
        repeat (4) step();
        check("stall_no_extra", n_out, 6);

        // Reset with two ops in flight.
        bus.out_ready = 1'b1;
        bus.in_x = 32'h3F80_0000; bus.in_y = 32'h3F80_0000; bus.in_op = 1'b0;
        bus.in_tag = 4'd1; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_tag = 4'd2;
        @(negedge clk);
        bus.in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            check("flush_out_valid", bus.out_valid, 0);
            @(negedge clk);
        end
        run_op("after_flush", 32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd4, 32'h4040_0000, 4'b0000);

        // Random normal pairs under random back-pressure.
        exp_q.delete(); n_acc = 0; n_out = 0; last_acc = 1'b0;
        bus.in_valid = 1'b0;
        for (int cyc = 0; cyc < 60000 && n_acc < 10000; cyc++) begin
            if (!bus.in_valid || last_acc) begin
                bus.in_valid = ($urandom_range(0, 4) != 0);
                if (bus.in_valid) rnd_ops();
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
        check("random_accepted", n_acc, 10000);
        check("random_drained", exp_q.size(), 0);
        check("random_count", n_out, n_acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
